// File: rtl/trap_ctrl.sv
// Trap sequencer: arbitrates exceptions, M-mode interrupts and MRET, then steps each
// accepted event through flush, drain, CSR commit and PC redirect.
module trap_ctrl #(
   parameter int XLEN         = 32,
   parameter int DRAIN_CYCLES = 2
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            exc_req,
   input  logic [3:0]      exc_cause,
   input  logic [XLEN-1:0] exc_pc,
   input  logic [XLEN-1:0] next_pc,
   input  logic [2:0]      irq_pend,
   input  logic [2:0]      irq_en,
   input  logic            mstatus_mie,
   input  logic            mret_req,
   input  logic            pipe_idle,
   output logic            stall,
   output logic            flush,
   output logic            trap_we,
   output logic            mret_we,
   output logic [XLEN-1:0] trap_mepc,
   output logic [XLEN-1:0] trap_mcause,
   output logic            redirect,
   output logic            redirect_mret,
   output logic            busy
);

   localparam int CW = $clog2(DRAIN_CYCLES + 1);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_DRAIN    = 2'd1;
   localparam logic [1:0] S_COMMIT   = 2'd2;
   localparam logic [1:0] S_REDIRECT = 2'd3;

   localparam logic [CW-1:0] CNT_MAX  = CW'(DRAIN_CYCLES);
   localparam logic [CW-1:0] CNT_EXIT = CW'(DRAIN_CYCLES - 1);

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [2:0]    irq;
   logic          irq_take;
   logic [3:0]    irq_code;

   assign irq      = irq_pend & irq_en;
   assign irq_take = mstatus_mie & (|irq);

   // Bit order is {MEI, MTI, MSI}; MSI outranks MTI even though it sits lower.
   always_comb begin
      irq_code = 4'd7;
      if (irq[2])
         irq_code = 4'd11;
      else if (irq[0])
         irq_code = 4'd3;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= S_IDLE;
         cnt           <= '0;
         trap_mepc     <= '0;
         trap_mcause   <= '0;
         redirect_mret <= 1'b0;
      end else begin
         // NOTE: state uses non-blocking assignments so every branch sees pre-edge values.
         case (state)
            S_IDLE: begin
               cnt <= '0;
               if (exc_req) begin
                  trap_mepc   <= exc_pc;
                  trap_mcause <= XLEN'(exc_cause);
                  state       <= S_DRAIN;
               end else if (irq_take) begin
                  trap_mepc   <= next_pc;
                  trap_mcause <= {1'b1, (XLEN-1)'(irq_code)};
                  state       <= S_DRAIN;
               end else if (mret_req) begin
                  redirect_mret <= 1'b1;
                  state         <= S_REDIRECT;
               end
            end
            S_DRAIN: begin
               if (cnt != CNT_MAX)
                  cnt <= cnt + CW'(1);
               if (cnt >= CNT_EXIT && pipe_idle)
                  state <= S_COMMIT;
            end
            S_COMMIT: begin
               redirect_mret <= 1'b0;
               state         <= S_REDIRECT;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Strobes are pure decodes of registered state, so they never glitch on inputs.
   assign busy     = (state != S_IDLE);
   assign stall    = busy;
   assign flush    = (state == S_DRAIN) && (cnt == '0);
   assign trap_we  = (state == S_COMMIT);
   assign redirect = (state == S_REDIRECT);
   assign mret_we  = redirect & redirect_mret;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: stimulus queues expected strobes with their cycle,
// a negedge monitor pops and compares them as the DUT raises flush/trap_we/redirect.
module tb_trap_ctrl;

   localparam int K_FLUSH = 0;
   localparam int K_TRAP  = 1;
   localparam int K_REDIR = 2;

   typedef struct {
      int          kind;
      int          cyc;
      logic [31:0] a;
      logic [31:0] b;
   } ev_t;

   logic        clock;
   logic        reset;
   logic        exc_req;
   logic [3:0]  exc_cause;
   logic [31:0] exc_pc;
   logic [31:0] next_pc;
   logic [2:0]  irq_pend;
   logic [2:0]  irq_en;
   logic        mstatus_mie;
   logic        mret_req;
   logic        pipe_idle;
   logic        stall;
   logic        flush;
   logic        trap_we;
   logic        mret_we;
   logic [31:0] trap_mepc;
   logic [31:0] trap_mcause;
   logic        redirect;
   logic        redirect_mret;
   logic        busy;

   int  n_checks = 0;
   int  n_err    = 0;
   int  cyc      = 0;
   ev_t q[$];

   trap_ctrl #(.XLEN(32), .DRAIN_CYCLES(2)) dut (
      .clock        (clock),
      .reset        (reset),
      .exc_req      (exc_req),
      .exc_cause    (exc_cause),
      .exc_pc       (exc_pc),
      .next_pc      (next_pc),
      .irq_pend     (irq_pend),
      .irq_en       (irq_en),
      .mstatus_mie  (mstatus_mie),
      .mret_req     (mret_req),
      .pipe_idle    (pipe_idle),
      .stall        (stall),
      .flush        (flush),
      .trap_we      (trap_we),
      .mret_we      (mret_we),
      .trap_mepc    (trap_mepc),
      .trap_mcause  (trap_mcause),
      .redirect     (redirect),
      .redirect_mret(redirect_mret),
      .busy         (busy)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(int kind, int c, logic [31:0] a, logic [31:0] b);
      ev_t e;
      e.kind = kind;
      e.cyc  = c;
      e.a    = a;
      e.b    = b;
      q.push_back(e);
   endtask

   // Full trap sequence with request sampled at the end of cycle n.
   task automatic push_trap(int n, int extra, logic [31:0] mepc, logic [31:0] mcause);
      push(K_FLUSH, n + 1, '0, '0);
      push(K_TRAP, n + 3 + extra, mepc, mcause);
      push(K_REDIR, n + 4 + extra, 32'd0, 32'd0);
   endtask

   task automatic take(int kind, logic [31:0] a, logic [31:0] b);
      ev_t   e;
      string nm;
      nm = (kind == K_FLUSH) ? "flush" : (kind == K_TRAP) ? "trap_we" : "redirect";
      if (q.size() == 0) begin
         check({"unexpected_", nm}, 32'd1, 32'd0);
         return;
      end
      e = q.pop_front();
      check({nm, "_kind"}, kind, e.kind);
      check({nm, "_cycle"}, cyc, e.cyc);
      if (kind != K_FLUSH) begin
         check({nm, "_a"}, a, e.a);
         check({nm, "_b"}, b, e.b);
      end
   endtask

   // Monitor: samples on the falling edge, away from the DUT's active edge.
   always @(negedge clock) begin
      if (!reset) begin
         if (flush)
            take(K_FLUSH, '0, '0);
         if (trap_we)
            take(K_TRAP, trap_mepc, trap_mcause);
         if (redirect)
            take(K_REDIR, {31'd0, redirect_mret}, {31'd0, mret_we});
         if (mret_we && !redirect)
            check("mret_we_without_redirect", 32'd1, 32'd0);
      end
   end

   task automatic step();
      @(negedge clock);
      #1;
   endtask

   task automatic wait_cyc(int c);
      while (cyc < c)
         step();
   endtask

   task automatic wait_idle();
      int k = 0;
      while ((busy || q.size() != 0) && k < 40) begin
         step();
         k++;
      end
      check("idle_timeout", {31'd0, (busy || q.size() != 0)}, 32'd0);
   endtask

   task automatic check_all_zero(string tag);
      check({tag, "_stall"}, {31'd0, stall}, 32'd0);
      check({tag, "_flush"}, {31'd0, flush}, 32'd0);
      check({tag, "_trap_we"}, {31'd0, trap_we}, 32'd0);
      check({tag, "_mret_we"}, {31'd0, mret_we}, 32'd0);
      check({tag, "_redirect"}, {31'd0, redirect}, 32'd0);
      check({tag, "_redirect_mret"}, {31'd0, redirect_mret}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_mepc"}, trap_mepc, 32'd0);
      check({tag, "_mcause"}, trap_mcause, 32'd0);
   endtask

   initial begin
      int n;
      reset       = 1'b1;
      exc_req     = 1'b0;
      exc_cause   = 4'd0;
      exc_pc      = '0;
      next_pc     = '0;
      irq_pend    = 3'b000;
      irq_en      = 3'b000;
      mstatus_mie = 1'b0;
      mret_req    = 1'b0;
      pipe_idle   = 1'b1;
      step();
      step();
      check_all_zero("reset");
      reset = 1'b0;
      step();

      // Synchronous exception, ecall-from-M.
      exc_req = 1'b1; exc_cause = 4'd11; exc_pc = 32'h100;
      n = cyc;
      push_trap(n, 0, 32'h100, 32'h0000_000B);
      step();
      exc_req = 1'b0;
      wait_cyc(n + 5);
      check("exc_busy_after", {31'd0, busy}, 32'd0);
      wait_idle();

      // All three interrupts: MEI wins; then without MEIP, MSI beats MTI.
      irq_en = 3'b111; mstatus_mie = 1'b1; next_pc = 32'h204; irq_pend = 3'b111;
      n = cyc;
      push_trap(n, 0, 32'h204, 32'h8000_000B);
      step();
      irq_pend = 3'b000;
      wait_idle();
      irq_pend = 3'b011;
      n = cyc;
      push_trap(n, 0, 32'h204, 32'h8000_0003);
      step();
      irq_pend = 3'b000;
      wait_idle();

      // Timer pending but globally masked, then unmasked.
      mstatus_mie = 1'b0; irq_en = 3'b010; irq_pend = 3'b010; next_pc = 32'h2A8;
      repeat (4) step();
      check("masked_irq_stall", {31'd0, stall}, 32'd0);
      mstatus_mie = 1'b1;
      n = cyc;
      push_trap(n, 0, 32'h2A8, 32'h8000_0007);
      step();
      irq_pend = 3'b000;
      wait_idle();

      // Pipeline busy for five drain cycles.
      exc_req = 1'b1; exc_cause = 4'd4; exc_pc = 32'h1F0; pipe_idle = 1'b0;
      n = cyc;
      push_trap(n, 3, 32'h1F0, 32'h0000_0004);
      step();
      exc_req = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0)
            step();
         check("drain_stall", {31'd0, stall}, 32'd1);
      end
      pipe_idle = 1'b1;
      wait_idle();

      // MRET alone.
      mret_req = 1'b1;
      n = cyc;
      push(K_REDIR, n + 1, 32'd1, 32'd1);
      step();
      mret_req = 1'b0;
      check("mret_busy_n1", {31'd0, busy}, 32'd1);
      step();
      check("mret_busy_n2", {31'd0, busy}, 32'd0);
      wait_idle();

      // MRET with a timer interrupt in the same cycle: interrupt wins.
      mret_req = 1'b1; irq_en = 3'b010; irq_pend = 3'b010; mstatus_mie = 1'b1; next_pc = 32'h500;
      n = cyc;
      push_trap(n, 0, 32'h500, 32'h8000_0007);
      step();
      mret_req = 1'b0; irq_pend = 3'b000;
      wait_idle();

      // Reset in the middle of COMMIT.
      exc_req = 1'b1; exc_cause = 4'd2; exc_pc = 32'h300;
      n = cyc;
      push(K_FLUSH, n + 1, '0, '0);
      push(K_TRAP, n + 3, 32'h300, 32'h0000_0002);
      step();
      exc_req = 1'b0;
      wait_cyc(n + 3);
      reset = 1'b1;
      #1;
      check_all_zero("async_reset");
      step();
      step();
      reset = 1'b0;
      repeat (6) step();
      check("post_reset_busy", {31'd0, busy}, 32'd0);

      // Normal exception after reset.
      exc_req = 1'b1; exc_cause = 4'd6; exc_pc = 32'h400;
      n = cyc;
      push_trap(n, 0, 32'h400, 32'h0000_0006);
      step();
      exc_req = 1'b0;
      wait_idle();

      check("queue_empty", q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
